// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, ALUOp classes, func fields and sequencer states
package alu_pkg;
  localparam logic [3:0] CTR_ADD  = 4'b0000;
  localparam logic [3:0] CTR_SUB  = 4'b0001;
  localparam logic [3:0] CTR_AND  = 4'b0010;
  localparam logic [3:0] CTR_OR   = 4'b0011;
  localparam logic [3:0] CTR_SLL  = 4'b0100;
  localparam logic [3:0] CTR_XOR  = 4'b0101;
  localparam logic [3:0] CTR_SLTU = 4'b0110;
  localparam logic [3:0] CTR_SLT  = 4'b0111;
  localparam logic [3:0] CTR_SRL  = 4'b1000;
  localparam logic [3:0] CTR_SRA  = 4'b1001;
  localparam logic [3:0] CTR_NOR  = 4'b1010;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_RTYPE = 4'b1000;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;

  function automatic logic is_md_func(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO};
  endfunction
endpackage

// File: rtl/md_iter_unit.sv
// md_iter_unit: radix-2 shift-add multiply / restoring divide datapath with sign fix-up
module md_iter_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kind_div,
  input  logic            sgn,
  input  logic            step,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  logic [2*XLEN-1:0] acc, mul_nx, div_nx, prod;
  logic [XLEN-1:0] dvs, abs_a, abs_b, q, r;
  logic [XLEN:0] msum, rsh, diff;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_q, neg_r, dz;

  // next-step values for both algorithms plus the signed/zero-divisor result fix-up
  always_comb begin
    abs_a  = sgn & a[XLEN-1] ? -a : a;
    abs_b  = sgn & b[XLEN-1] ? -b : b;
    msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    mul_nx = {msum, acc[XLEN-1:1]};
    rsh    = acc[2*XLEN-1:XLEN-1];
    diff   = rsh - {1'b0, dvs};
    div_nx = diff[XLEN] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod   = neg_q ? -acc : acc;
    q      = acc[XLEN-1:0];
    r      = acc[2*XLEN-1:XLEN];
    res_hi = is_div ? (neg_r ? -r : r) : prod[2*XLEN-1:XLEN];
    res_lo = is_div ? (dz ? '1 : neg_q ? -q : q) : prod[XLEN-1:0];
    done   = cnt == CNT_W'(1);
  end

  // operand capture on start, one iteration per step cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (start) begin
      acc    <= {{XLEN{1'b0}}, abs_a};
      dvs    <= abs_b;
      cnt    <= CNT_W'(XLEN);
      is_div <= kind_div;
      neg_q  <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r  <= sgn & a[XLEN-1];
      dz     <= b == '0;
    end else if (step) begin
      acc <= is_div ? div_nx : mul_nx;
      cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: ALU control decode plus multiply/divide sequencer with HI/LO and stall
module alu_md_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [5:0]      func,
  input  logic [3:0]      ALUOp,
  input  logic            ex_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            ALUSrcA,
  output logic [3:0]      ALUCtr,
  output logic            md_stall,
  output logic            md_busy,
  output logic            md_rsel,
  output logic [XLEN-1:0] md_rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  md_state_e state, nxt;
  logic qual, rtype, is_mul, is_div, sgn, accept, done;
  logic [XLEN-1:0] fix_hi, fix_lo;

  // ALU operation decode; anything unrecognised falls back to ADD
  always_comb begin
    ALUSrcA = 1'b0;
    ALUCtr  = CTR_ADD;
    if (ALUOp == OP_RTYPE)
      case (func)
        F_SUB:   ALUCtr = CTR_SUB;
        F_AND:   ALUCtr = CTR_AND;
        F_OR:    ALUCtr = CTR_OR;
        F_XOR:   ALUCtr = CTR_XOR;
        F_NOR:   ALUCtr = CTR_NOR;
        F_SLTU:  ALUCtr = CTR_SLTU;
        F_SLT:   ALUCtr = CTR_SLT;
        F_SLL:   begin ALUCtr = CTR_SLL; ALUSrcA = 1'b1; end
        F_SRL:   begin ALUCtr = CTR_SRL; ALUSrcA = 1'b1; end
        F_SRA:   begin ALUCtr = CTR_SRA; ALUSrcA = 1'b1; end
        default: ALUCtr = CTR_ADD;
      endcase
    else
      case (ALUOp)
        OP_SUB:  ALUCtr = CTR_SUB;
        OP_AND:  ALUCtr = CTR_AND;
        OP_OR:   ALUCtr = CTR_OR;
        OP_SLTU: ALUCtr = CTR_SLTU;
        OP_SLT:  ALUCtr = CTR_SLT;
        OP_XOR:  ALUCtr = CTR_XOR;
        default: ALUCtr = CTR_ADD;
      endcase
  end

  // sequencer state register
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) state <= S_IDLE;
    else state <= nxt;

  // sequencer next state: accept only from IDLE, RUN until the last iteration, one FIX cycle
  always_comb begin
    nxt = state == S_IDLE ? (accept ? S_RUN : S_IDLE) :
          state == S_RUN  ? (done ? S_FIX : S_RUN) : S_IDLE;
  end

  // handshake outputs: MD instructions stall while the sequencer is busy
  always_comb begin
    qual     = ex_valid & ~flush;
    rtype    = ALUOp == OP_RTYPE;
    is_mul   = rtype & (func == F_MULT | func == F_MULTU);
    is_div   = rtype & (func == F_DIV | func == F_DIVU);
    sgn      = func == F_MULT | func == F_DIV;
    md_busy  = state != S_IDLE;
    accept   = qual & (is_mul | is_div) & ~md_busy;
    md_stall = qual & rtype & is_md_func(func) & md_busy;
    md_rsel  = qual & rtype & (func == F_MFHI | func == F_MFLO) & ~md_busy;
    md_rdata = func == F_MFHI ? hi : lo;
  end

  // HI/LO: result write in FIX, direct moves only while idle
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (qual & rtype & ~md_busy) begin
      if (func == F_MTHI) hi <= src_a;
      if (func == F_MTLO) lo <= src_a;
    end

  md_iter_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
    .clk     (CLK),
    .rst_n   (RST_n),
    .start   (accept),
    .kind_div(is_div),
    .sgn     (sgn),
    .step    (state == S_RUN),
    .a       (src_a),
    .b       (src_b),
    .done    (done),
    .res_hi  (fix_hi),
    .res_lo  (fix_lo)
  );
endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb_alu_md_ctrl: randomized bench against a behavioural HI/LO/latency model with literal anchors
module tb_alu_md_ctrl;
  localparam int XLEN = 32;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;

  logic CLK = 1'b0, RST_n;
  logic [5:0] func;
  logic [3:0] ALUOp;
  logic ex_valid, flush;
  logic [XLEN-1:0] src_a, src_b;
  logic ALUSrcA, md_stall, md_busy, md_rsel;
  logic [3:0] ALUCtr;
  logic [XLEN-1:0] md_rdata, hi, lo;

  int vectors = 0, fails = 0;
  int left;
  logic [XLEN-1:0] m_hi, m_lo, p_hi, p_lo;
  logic [3:0] r_ctr [64];
  logic [3:0] op_ctr [16];
  logic r_sa [64];
  logic [5:0] md_f [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
  logic [31:0] spec_v [6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h2};
  logic [14:0] dec_tab [20] = '{
    {1'b0, 4'h8, 6'h20, 4'h0}, {1'b0, 4'h8, 6'h22, 4'h1}, {1'b0, 4'h8, 6'h24, 4'h2},
    {1'b0, 4'h8, 6'h25, 4'h3}, {1'b0, 4'h8, 6'h26, 4'h5}, {1'b0, 4'h8, 6'h27, 4'hA},
    {1'b0, 4'h8, 6'h2B, 4'h6}, {1'b0, 4'h8, 6'h2A, 4'h7}, {1'b1, 4'h8, 6'h00, 4'h4},
    {1'b1, 4'h8, 6'h02, 4'h8}, {1'b1, 4'h8, 6'h03, 4'h9}, {1'b0, 4'h8, 6'h3F, 4'h0},
    {1'b0, 4'h0, 6'h00, 4'h0}, {1'b0, 4'h1, 6'h00, 4'h1}, {1'b0, 4'h2, 6'h02, 4'h2},
    {1'b0, 4'h3, 6'h03, 4'h3}, {1'b0, 4'h5, 6'h22, 4'h6}, {1'b0, 4'h6, 6'h00, 4'h7},
    {1'b0, 4'h7, 6'h00, 4'h5}, {1'b0, 4'hF, 6'h03, 4'h0}};

  alu_md_ctrl #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST_n(RST_n), .func(func), .ALUOp(ALUOp), .ex_valid(ex_valid), .flush(flush),
    .src_a(src_a), .src_b(src_b), .ALUSrcA(ALUSrcA), .ALUCtr(ALUCtr), .md_stall(md_stall),
    .md_busy(md_busy), .md_rsel(md_rsel), .md_rdata(md_rdata), .hi(hi), .lo(lo));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (f == F_MULT) return longint'(sa) * longint'(sb);
    if (f == F_MULTU) return {32'h0, a} * {32'h0, b};
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (f == F_DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // behavioural model: results land XLEN+1 cycles after acceptance, moves land at the next edge
  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_hi <= '0;
      m_lo <= '0;
      left <= 0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (ex_valid && !flush && ALUOp == 4'h8) begin
      if (func inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
        {p_hi, p_lo} <= md_ref(func, src_a, src_b);
        left <= XLEN + 1;
      end
      if (func == F_MTHI) m_hi <= src_a;
      if (func == F_MTLO) m_lo <= src_a;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge CLK) begin
    logic q, rt, idle, ersel;
    q     = ex_valid && !flush;
    rt    = ALUOp == 4'h8;
    idle  = left == 0;
    ersel = q && rt && idle && (func == F_MFHI || func == F_MFLO);
    check("busy", 32'(md_busy), 32'(!idle));
    check("stall", 32'(md_stall), 32'(q && rt && !idle && (func inside {md_f})));
    check("rsel", 32'(md_rsel), 32'(ersel));
    if (ersel) check("rdata", md_rdata, func == F_MFHI ? m_hi : m_lo);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("aluctr", 32'(ALUCtr), 32'(rt ? r_ctr[func] : op_ctr[ALUOp]));
    check("alusrca", 32'(ALUSrcA), 32'(rt && r_sa[func]));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1;
    ALUOp = 4'h8;
    func = f;
    src_a = a;
    src_b = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!md_busy) break;
      n++;
    end
  endtask

  task automatic md_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(f, a, b);
    tick();
    ex_valid = 1'b0;
    wait_idle(n);
    check({name, "_busy_len"}, n, 33);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    tick();
  endtask

  initial begin
    int n;
    logic [14:0] e;
    for (int i = 0; i < 64; i++) begin r_ctr[i] = 4'h0; r_sa[i] = 1'b0; end
    for (int i = 0; i < 16; i++) op_ctr[i] = 4'h0;
    r_ctr[6'h22] = 4'h1; r_ctr[6'h24] = 4'h2; r_ctr[6'h25] = 4'h3; r_ctr[6'h26] = 4'h5;
    r_ctr[6'h27] = 4'hA; r_ctr[6'h2B] = 4'h6; r_ctr[6'h2A] = 4'h7;
    r_ctr[6'h00] = 4'h4; r_ctr[6'h02] = 4'h8; r_ctr[6'h03] = 4'h9;
    r_sa[6'h00] = 1'b1; r_sa[6'h02] = 1'b1; r_sa[6'h03] = 1'b1;
    op_ctr[1] = 4'h1; op_ctr[2] = 4'h2; op_ctr[3] = 4'h3; op_ctr[5] = 4'h6; op_ctr[6] = 4'h7; op_ctr[7] = 4'h5;
    RST_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; ALUOp = 4'h0; func = 6'h0; src_a = '0; src_b = '0;
    repeat (2) tick();
    check("rst_busy", 32'(md_busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    RST_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      e = dec_tab[i];
      ALUOp = e[13:10];
      func = e[9:4];
      #1;
      check("dec_ctr", 32'(ALUCtr), 32'(e[3:0]));
      check("dec_srca", 32'(ALUSrcA), 32'(e[14]));
      tick();
    end

    md_op("mult", F_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_op("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    md_op("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    md_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    md_op("div_z", F_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    md_op("divu_z", F_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);

    issue(F_MULT, 32'd5, 32'd6);
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    issue(F_MFLO, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!md_stall) break;
      n++;
    end
    check("mflo_stall_len", n, 31);
    check("mflo_rdata", md_rdata, 32'd30);
    check("mflo_rsel", 32'(md_rsel), 1);
    tick();
    ex_valid = 1'b0;

    issue(F_MULT, 32'd3, 32'd4);
    tick();
    issue(F_MULT, 32'd9, 32'd9);
    #1;
    check("second_mult_stall", 32'(md_stall), 1);
    repeat (5) tick();
    ex_valid = 1'b0;
    wait_idle(n);
    check("second_mult_lo", lo, 32'd12);
    tick();
    check("second_mult_idle", 32'(md_busy), 0);

    issue(F_MULT, 32'd3, 32'd3);
    flush = 1'b1;
    tick();
    check("flush_busy", 32'(md_busy), 0);
    flush = 1'b0;
    ex_valid = 1'b0;
    tick();

    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    ex_valid = 1'b0;
    repeat (9) tick();
    #2 RST_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(md_busy), 0);
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    tick();
    RST_n = 1'b1;
    tick();
    issue(F_MTHI, 32'h1234, 32'h0);
    tick();
    issue(F_MFHI, 32'h0, 32'h0);
    #1;
    check("mfhi_rdata", md_rdata, 32'h1234);
    check("mfhi_stall", 32'(md_stall), 0);
    check("mfhi_rsel", 32'(md_rsel), 1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      ALUOp = ($urandom % 4 == 0) ? 4'($urandom) : 4'h8;
      func = ($urandom % 2 == 0) ? md_f[$urandom % 8] : 6'($urandom);
      src_a = ($urandom % 4 == 0) ? spec_v[$urandom % 6] : $urandom;
      src_b = ($urandom % 4 == 0) ? spec_v[$urandom % 6] : (($urandom % 2 == 0) ? $urandom % 50 : $urandom);
      ex_valid = $urandom % 4 != 0;
      flush = $urandom % 8 == 0;
      RST_n = $urandom % 700 != 0;
      tick();
    end
    RST_n = 1'b1;
    ex_valid = 1'b0;
    repeat (40) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/alu_md_ctrl.md
Name: alu_md_ctrl

Overview:
- Successor to the combinational ALU control decoder, parametrised on datapath width XLEN.
- Keeps the ALUOp/func -> ALUSrcA/ALUCtr decode and extends it with SRL, SRA and NOR.
- Adds an iterative multiply/divide sequencer (MULT/MULTU/DIV/DIVU) with HI/LO registers, MFHI/MFLO/MTHI/MTLO and a pipeline stall output.
- Sits in the EX stage beside the ALU; the hazard unit consumes md_stall.

Parameters:
- XLEN, 32, operand/HI/LO width (even, >= 8)
- CNT_W, $clog2(XLEN+1), iteration counter width (derived; do not override)

Ports:
- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- func  in  6  instruction function field
- ALUOp  in  4  ALU operation class from main control
- ex_valid  in  1  EX-stage instruction valid
- flush  in  1  kill the EX-stage instruction this cycle
- src_a  in  XLEN  rs operand (forwarded)
- src_b  in  XLEN  rt operand (forwarded)
- ALUSrcA  out  1  1 = ALU A input takes shamt
- ALUCtr  out  4  ALU operation select
- md_stall  out  1  hold IF/ID/EX this cycle
- md_busy  out  1  sequencer not idle
- md_rsel  out  1  write-back takes md_rdata instead of ALU result
- md_rdata  out  XLEN  HI for MFHI, LO for MFLO
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Decode is combinational, and an unknown func/ALUOp gives ADD, ALUSrcA=0.
  - ALUCtr codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, XOR 0101, SLTU 0110, SLT 0111, SRL 1000, SRA 1001, NOR 1010.
  - ALUOp 1000 = R-type, decoded by func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101011 SLTU, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA.
  - ALUSrcA=1 only for SLL/SRL/SRA.
  - Other ALUOp values: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLTU, 0110 SLT, 0111 XOR.
- MD funcs (ALUOp=1000 only): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.
- Qualifier: an instruction is qualified when ex_valid & ~flush.
- md_stall = qualified & MD func & state != IDLE. Stalled instructions are not accepted.
- States: IDLE, RUN, FIX.
  - IDLE + qualified MULT/DIV (accept cycle T):
    - latch |src_a| and |src_b|; abs applies only for signed ops, unsigned ops latch raw values
    - latch the result signs: quotient/product sign = sa^sb, remainder sign = sa
    - latch the op kind; counter = XLEN
    - go to RUN.
  - RUN: one radix-2 step per cycle, counter decrements; at counter == 1 go to FIX.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract.
  - FIX: apply the sign corrections, write HI/LO, go to IDLE.
- Timing: md_busy is high for cycles T+1 through T+XLEN+1. The new HI/LO are visible at T+XLEN+2. At XLEN=32 that is 34 cycles total.
- MTHI/MTLO in IDLE: write src_a to hi/lo at the next edge, single cycle.
- MFHI/MFLO in IDLE: md_rsel=1 and md_rdata=hi/lo, combinational, same cycle. md_rsel=0 otherwise.
- Divide by zero (B == 0) still runs the full latency and gives LO = all ones, HI = src_a unmodified. Signed overflow (MIN / -1) gives LO = MIN, HI = 0.
- flush and ex_valid only gate acceptance. A running operation is never cancelled.
- Reset, asynchronous and valid at any time including mid-operation: state=IDLE, counter=0, hi=0, lo=0, datapath registers 0. All outputs then follow IDLE decode: md_busy=0, md_stall=0, md_rsel=0.

Decomposition:
- Shared package alu_pkg holds:
  - ALUCtr code constants
  - ALUOp class constants
  - func constants, including the MD funcs
  - sequencer state encoding.
- One sub-module, md_iter_unit: holds the RUN/FIX datapath (accumulator, counter, sign fix) with start/kind/done ports.
- Decode and the stall/handshake logic stay in alu_md_ctrl.

Test Plan:
- Decode regression: every ALUOp/func pair listed, plus SRL, SRA and NOR, gives the ALUCtr above. ALUSrcA=1 only for func 000000/000010/000011. Unknown func 111111 gives ADD.
- MULT with src_a=7, src_b=0xFFFFFFFD (-3): md_busy high for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF*2 gives hi=1, lo=0xFFFFFFFE.
- DIVU 100/7 gives lo=14, hi=2. DIV -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 gives lo=0x80000000, hi=0.
- DIV 5/0 gives lo=0xFFFFFFFF, hi=5.
- Hazards and flush:
  - MFLO issued at T+3 after a MULT keeps md_stall=1 until T+34. In that cycle md_stall=0 and md_rdata equals the new lo.
  - A second MULT issued while busy stalls and is not accepted.
  - MULT with flush=1 is not accepted and md_busy stays 0.
- Reset and moves:
  - Assert RST_n=0 mid-RUN (cycle T+10), asynchronously between edges: md_busy=0, hi=lo=0 immediately.
  - After release, MTHI 0x1234 then MFHI returns 0x1234 with md_stall=0.
